// File: rtl/tm1638_responder.sv
// TM1638 device-side responder for the LED&KEY three-wire link.
// Decodes command/address/data bytes into display RAM and shifts key-scan data back on reads.
module tm1638_responder #(
   parameter int SYNC_STAGES = 2
) (
   input  logic         clk,
   input  logic         rst_n,
   input  logic         lk_clk,
   input  logic         lk_stb,
   input  logic         lk_dio_in,
   output logic         lk_dio_out,
   output logic         lk_dio_oe,
   input  logic [31:0]  keys,
   output logic [127:0] disp_ram,
   output logic         disp_on,
   output logic [2:0]   brightness,
   output logic         frame_done
);

   typedef enum logic [2:0] {
      S_IDLE,
      S_CMD,
      S_WDATA,
      S_RDATA,
      S_IGNORE
   } state_t;

   logic [SYNC_STAGES-1:0] clk_sync_q, clk_sync_d;
   logic [SYNC_STAGES-1:0] stb_sync_q, stb_sync_d;
   logic [SYNC_STAGES-1:0] dio_sync_q, dio_sync_d;
   logic                   clk_prev_q, clk_prev_d;
   logic                   stb_prev_q, stb_prev_d;

   state_t           state_q, state_d;
   logic [2:0]       bit_cnt_q, bit_cnt_d;
   logic [7:0]       shift_q, shift_d;
   logic [3:0]       addr_q, addr_d;
   logic             fixed_q, fixed_d;
   logic [15:0][7:0] ram_q, ram_d;
   logic             disp_on_q, disp_on_d;
   logic [2:0]       bright_q, bright_d;
   logic             dio_out_q, dio_out_d;
   logic             dio_oe_q, dio_oe_d;
   logic             frame_done_q, frame_done_d;
   logic             got_byte_q, got_byte_d;
   logic [31:0]      snap_q, snap_d;
   logic [5:0]       rd_idx_q, rd_idx_d;

   logic       clk_rise, clk_fall, stb_rise, stb_fall, dio_bit;
   logic [7:0] byte_next;

   always_comb begin
      clk_sync_d = {clk_sync_q[SYNC_STAGES-2:0], lk_clk};
      stb_sync_d = {stb_sync_q[SYNC_STAGES-2:0], lk_stb};
      dio_sync_d = {dio_sync_q[SYNC_STAGES-2:0], lk_dio_in};
      clk_prev_d = clk_sync_q[SYNC_STAGES-1];
      stb_prev_d = stb_sync_q[SYNC_STAGES-1];
   end

   // NOTE: synchronizers are left unreset so that releasing rst_n mid-frame cannot fabricate a strobe edge.
   always_ff @(posedge clk) begin
      clk_sync_q <= clk_sync_d;
      stb_sync_q <= stb_sync_d;
      dio_sync_q <= dio_sync_d;
      clk_prev_q <= clk_prev_d;
      stb_prev_q <= stb_prev_d;
   end

   assign clk_rise = clk_sync_q[SYNC_STAGES-1] & ~clk_prev_q;
   assign clk_fall = ~clk_sync_q[SYNC_STAGES-1] & clk_prev_q;
   assign stb_rise = stb_sync_q[SYNC_STAGES-1] & ~stb_prev_q;
   assign stb_fall = ~stb_sync_q[SYNC_STAGES-1] & stb_prev_q;
   assign dio_bit  = dio_sync_q[SYNC_STAGES-1];

   always_comb begin
      state_d      = state_q;
      bit_cnt_d    = bit_cnt_q;
      shift_d      = shift_q;
      addr_d       = addr_q;
      fixed_d      = fixed_q;
      ram_d        = ram_q;
      disp_on_d    = disp_on_q;
      bright_d     = bright_q;
      dio_out_d    = dio_out_q;
      dio_oe_d     = dio_oe_q;
      frame_done_d = 1'b0;
      got_byte_d   = got_byte_q;
      snap_d       = snap_q;
      rd_idx_d     = rd_idx_q;
      byte_next    = {dio_bit, shift_q[7:1]};

      // Strobe release ends the frame from any state and masks a coincident clock edge.
      if (stb_rise) begin
         state_d      = S_IDLE;
         dio_oe_d     = 1'b0;
         frame_done_d = got_byte_q;
         got_byte_d   = 1'b0;
         bit_cnt_d    = 3'd0;
      end else begin
         unique case (state_q)
            S_IDLE: begin
               if (stb_fall) begin
                  state_d    = S_CMD;
                  bit_cnt_d  = 3'd0;
                  got_byte_d = 1'b0;
               end
            end
            S_CMD: begin
               if (clk_rise) begin
                  shift_d   = byte_next;
                  bit_cnt_d = bit_cnt_q + 3'd1;
                  if (bit_cnt_q == 3'd7) begin
                     got_byte_d = 1'b1;
                     case (byte_next[7:6])
                        2'b01: begin
                           fixed_d = byte_next[2];
                           if (byte_next[1]) begin
                              snap_d   = keys;
                              rd_idx_d = 6'd0;
                              state_d  = S_RDATA;
                           end else begin
                              state_d = S_IGNORE;
                           end
                        end
                        2'b10: begin
                           disp_on_d = byte_next[3];
                           bright_d  = byte_next[2:0];
                           state_d   = S_IGNORE;
                        end
                        2'b11: begin
                           addr_d  = byte_next[3:0];
                           state_d = S_WDATA;
                        end
                        default: state_d = S_IGNORE;
                     endcase
                  end
               end
            end
            S_WDATA: begin
               if (clk_rise) begin
                  shift_d   = byte_next;
                  bit_cnt_d = bit_cnt_q + 3'd1;
                  if (bit_cnt_q == 3'd7) begin
                     got_byte_d     = 1'b1;
                     ram_d[addr_q]  = byte_next;
                     if (!fixed_q) begin
                        addr_d = addr_q + 4'd1;
                     end
                  end
               end
            end
            S_RDATA: begin
               if (clk_fall) begin
                  if (rd_idx_q < 6'd32) begin
                     dio_out_d = snap_q[rd_idx_q[4:0]];
                     dio_oe_d  = 1'b1;
                     rd_idx_d  = rd_idx_q + 6'd1;
                  end else begin
                     dio_oe_d = 1'b0;
                  end
               end
            end
            default: ;
         endcase
      end
   end

   always_ff @(posedge clk) begin
      if (!rst_n) begin
         state_q      <= S_IDLE;
         bit_cnt_q    <= 3'd0;
         shift_q      <= 8'd0;
         addr_q       <= 4'd0;
         fixed_q      <= 1'b0;
         ram_q        <= '0;
         disp_on_q    <= 1'b0;
         bright_q     <= 3'd0;
         dio_out_q    <= 1'b0;
         dio_oe_q     <= 1'b0;
         frame_done_q <= 1'b0;
         got_byte_q   <= 1'b0;
         snap_q       <= 32'd0;
         rd_idx_q     <= 6'd0;
      end else begin
         state_q      <= state_d;
         bit_cnt_q    <= bit_cnt_d;
         shift_q      <= shift_d;
         addr_q       <= addr_d;
         fixed_q      <= fixed_d;
         ram_q        <= ram_d;
         disp_on_q    <= disp_on_d;
         bright_q     <= bright_d;
         dio_out_q    <= dio_out_d;
         dio_oe_q     <= dio_oe_d;
         frame_done_q <= frame_done_d;
         got_byte_q   <= got_byte_d;
         snap_q       <= snap_d;
         rd_idx_q     <= rd_idx_d;
      end
   end

   assign disp_ram   = ram_q;
   assign disp_on    = disp_on_q;
   assign brightness = bright_q;
   assign lk_dio_out = dio_out_q;
   assign lk_dio_oe  = dio_oe_q;
   assign frame_done = frame_done_q;

endmodule

// File: tb/tb_tm1638_responder.sv
// Bench for tm1638_responder: bit-banged initiator frames, table-driven write vectors,
// and a queue scoreboard for key-read bits.
module tb_tm1638_responder;

   localparam int H = 8;

   logic         clk = 1'b0;
   logic         rst_n = 1'b0;
   logic         lk_clk = 1'b1;
   logic         lk_stb = 1'b1;
   logic         lk_dio_in = 1'b1;
   logic [31:0]  keys = 32'd0;
   logic         lk_dio_out;
   logic         lk_dio_oe;
   logic [127:0] disp_ram;
   logic         disp_on;
   logic [2:0]   brightness;
   logic         frame_done;

   tm1638_responder #(.SYNC_STAGES(2)) dut (
      .clk        (clk),
      .rst_n      (rst_n),
      .lk_clk     (lk_clk),
      .lk_stb     (lk_stb),
      .lk_dio_in  (lk_dio_in),
      .lk_dio_out (lk_dio_out),
      .lk_dio_oe  (lk_dio_oe),
      .keys       (keys),
      .disp_ram   (disp_ram),
      .disp_on    (disp_on),
      .brightness (brightness),
      .frame_done (frame_done)
   );

   always #5 clk = ~clk;

   int checks = 0;
   int errors = 0;
   int fd_count = 0;
   int oe_count = 0;

   always @(negedge clk) begin
      if (frame_done) fd_count++;
      if (lk_dio_oe) oe_count++;
   end

   initial begin
      #1_000_000;
      $display("FAIL watchdog timeout");
      $fatal(1, "watchdog");
   end

   typedef struct {
      logic [7:0] dcmd;
      logic [7:0] acmd;
      logic [7:0] d [3];
      int         n;
      int         idx_a;
      logic [7:0] val_a;
      int         idx_b;
      logic [7:0] val_b;
   } vec_t;

   vec_t             vecs [4];
   logic [15:0][7:0] model_ram;
   logic [3:0]       model_addr;
   logic             model_fixed;
   logic             exp_q [$];

   task automatic check(input string name, input logic [127:0] act, input logic [127:0] exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s actual=%0h required=%0h", name, act, exp);
      end
   endtask

   task automatic wait_clk(input int n);
      repeat (n) @(posedge clk);
      #1;
   endtask

   task automatic lk_bit(input logic b);
      lk_clk = 1'b0;
      lk_dio_in = b;
      wait_clk(H);
      lk_clk = 1'b1;
      wait_clk(H);
   endtask

   task automatic lk_byte(input logic [7:0] b);
      for (int i = 0; i < 8; i++) lk_bit(b[i]);
   endtask

   task automatic stb_low();
      lk_stb = 1'b0;
      wait_clk(H);
   endtask

   task automatic stb_high();
      lk_stb = 1'b1;
      lk_dio_in = 1'b1;
      wait_clk(2 * H);
   endtask

   task automatic cmd_frame(input logic [7:0] b);
      stb_low();
      lk_byte(b);
      stb_high();
   endtask

   function automatic logic [7:0] ram_byte(input int idx);
      logic [127:0] r;
      r = disp_ram;
      return r[idx*8 +: 8];
   endfunction

   initial begin
      int           fd_base;
      int           oe_base;
      logic         e;
      logic [31:0]  got;
      logic [127:0] exp_ram;

      vecs[0] = '{dcmd: 8'h40, acmd: 8'hC0, d: '{8'h3F, 8'h06, 8'h5B}, n: 3,
                  idx_a: 0, val_a: 8'h3F, idx_b: 2, val_b: 8'h5B};
      vecs[1] = '{dcmd: 8'h44, acmd: 8'hCF, d: '{8'h11, 8'h22, 8'h00}, n: 2,
                  idx_a: 15, val_a: 8'h22, idx_b: 1, val_b: 8'h06};
      vecs[2] = '{dcmd: 8'h40, acmd: 8'hCF, d: '{8'hAA, 8'hBB, 8'h00}, n: 2,
                  idx_a: 15, val_a: 8'hAA, idx_b: 0, val_b: 8'hBB};
      vecs[3] = '{dcmd: 8'h44, acmd: 8'hC5, d: '{8'h77, 8'h00, 8'h00}, n: 1,
                  idx_a: 5, val_a: 8'h77, idx_b: 6, val_b: 8'h00};

      // Reset values
      rst_n = 1'b0;
      wait_clk(6);
      @(negedge clk);
      check("rst_ram", disp_ram, '0);
      check("rst_disp_on", {127'd0, disp_on}, 128'd0);
      check("rst_brightness", {125'd0, brightness}, 128'd0);
      check("rst_oe", {127'd0, lk_dio_oe}, 128'd0);
      check("rst_dio_out", {127'd0, lk_dio_out}, 128'd0);
      check("rst_frame_done", {127'd0, frame_done}, 128'd0);
      rst_n = 1'b1;
      wait_clk(4);

      // Display control commands
      fd_base = fd_count;
      cmd_frame(8'h8F);
      @(negedge clk);
      check("ctl8f_disp_on", {127'd0, disp_on}, 128'd1);
      check("ctl8f_brightness", {125'd0, brightness}, 128'd7);
      check("ctl8f_frame_done", 128'(fd_count - fd_base), 128'd1);
      check("ctl8f_ram", disp_ram, '0);

      cmd_frame(8'h83);
      @(negedge clk);
      check("ctl83_disp_on", {127'd0, disp_on}, 128'd0);
      check("ctl83_brightness", {125'd0, brightness}, 128'd3);

      fd_base = fd_count;
      cmd_frame(8'h25);
      @(negedge clk);
      check("cmd00_brightness", {125'd0, brightness}, 128'd3);
      check("cmd00_frame_done", 128'(fd_count - fd_base), 128'd1);
      check("cmd00_ram", disp_ram, '0);

      // Table-driven write frames
      model_ram = '0;
      model_addr = 4'd0;
      model_fixed = 1'b0;
      for (int v = 0; v < 4; v++) begin
         fd_base = fd_count;
         cmd_frame(vecs[v].dcmd);
         model_fixed = vecs[v].dcmd[2];
         stb_low();
         lk_byte(vecs[v].acmd);
         model_addr = vecs[v].acmd[3:0];
         for (int j = 0; j < vecs[v].n; j++) begin
            lk_byte(vecs[v].d[j]);
            model_ram[model_addr] = vecs[v].d[j];
            if (!model_fixed) model_addr = model_addr + 4'd1;
         end
         stb_high();
         @(negedge clk);
         check($sformatf("vec%0d_byte%0d", v, vecs[v].idx_a), 128'(ram_byte(vecs[v].idx_a)), 128'(vecs[v].val_a));
         check($sformatf("vec%0d_byte%0d", v, vecs[v].idx_b), 128'(ram_byte(vecs[v].idx_b)), 128'(vecs[v].val_b));
         check($sformatf("vec%0d_ram", v), disp_ram, model_ram);
         check($sformatf("vec%0d_frame_done", v), 128'(fd_count - fd_base), 128'd2);
      end

      // Address byte then a partial byte: no write, one frame_done, oe never driven
      fd_base = fd_count;
      oe_base = oe_count;
      stb_low();
      lk_byte(8'hC2);
      for (int i = 0; i < 5; i++) lk_bit(1'b1);
      stb_high();
      @(negedge clk);
      check("partial_ram", disp_ram, model_ram);
      check("partial_frame_done", 128'(fd_count - fd_base), 128'd1);
      check("partial_oe", 128'(oe_count - oe_base), 128'd0);

      // 8th clock rise coincides with strobe rise: the strobe wins, no write
      fd_base = fd_count;
      stb_low();
      lk_byte(8'hC9);
      for (int i = 0; i < 7; i++) lk_bit(1'b1);
      lk_clk = 1'b0;
      lk_dio_in = 1'b1;
      wait_clk(H);
      lk_clk = 1'b1;
      lk_stb = 1'b1;
      wait_clk(2 * H);
      @(negedge clk);
      check("stb_wins_ram", disp_ram, model_ram);
      check("stb_wins_frame_done", 128'(fd_count - fd_base), 128'd1);

      // Key read with scoreboard; keys change mid-read
      keys = 32'h8001_2040;
      exp_q.delete();
      for (int i = 0; i < 32; i++) exp_q.push_back(keys[i]);
      fd_base = fd_count;
      got = '0;
      stb_low();
      lk_byte(8'h42);
      lk_dio_in = 1'b1;
      for (int i = 0; i < 32; i++) begin
         lk_clk = 1'b0;
         wait_clk(H);
         if (i == 16) keys = 32'h0F0F_F0F0;
         lk_clk = 1'b1;
         @(negedge clk);
         e = exp_q.pop_front();
         got[i] = lk_dio_out;
         check($sformatf("rd_bit%0d", i), {127'd0, lk_dio_out}, {127'd0, e});
         if (i == 0 || i == 31) check($sformatf("rd_oe%0d", i), {127'd0, lk_dio_oe}, 128'd1);
         wait_clk(H - 1);
      end
      check("rd_word", {96'd0, got}, {96'd0, 32'h8001_2040});
      lk_clk = 1'b0;
      wait_clk(H);
      @(negedge clk);
      check("rd_oe_after_bit31", {127'd0, lk_dio_oe}, 128'd0);
      lk_clk = 1'b1;
      wait_clk(H);
      stb_high();
      @(negedge clk);
      check("rd_oe_after_stb", {127'd0, lk_dio_oe}, 128'd0);
      check("rd_frame_done", 128'(fd_count - fd_base), 128'd1);
      check("rd_ram", disp_ram, model_ram);

      // Short read cut off by strobe rise while clock is low
      keys = 32'h0000_0007;
      stb_low();
      lk_byte(8'h42);
      for (int i = 0; i < 2; i++) lk_bit(1'b1);
      lk_clk = 1'b0;
      wait_clk(H);
      @(negedge clk);
      check("short_rd_oe", {127'd0, lk_dio_oe}, 128'd1);
      check("short_rd_bit2", {127'd0, lk_dio_out}, 128'd1);
      lk_stb = 1'b1;
      wait_clk(H);
      @(negedge clk);
      check("short_rd_oe_drop", {127'd0, lk_dio_oe}, 128'd0);
      lk_clk = 1'b1;
      wait_clk(2 * H);

      // Reset in the middle of a write frame, after one of two bytes
      cmd_frame(8'h8F);
      cmd_frame(8'h44);
      stb_low();
      lk_byte(8'hC3);
      lk_byte(8'h55);
      for (int i = 0; i < 4; i++) lk_bit(1'b1);
      rst_n = 1'b0;
      wait_clk(3);
      @(negedge clk);
      check("midrst_ram", disp_ram, '0);
      check("midrst_disp_on", {127'd0, disp_on}, 128'd0);
      check("midrst_brightness", {125'd0, brightness}, 128'd0);
      check("midrst_oe", {127'd0, lk_dio_oe}, 128'd0);
      check("midrst_dio_out", {127'd0, lk_dio_out}, 128'd0);
      rst_n = 1'b1;
      wait_clk(2);
      fd_base = fd_count;
      for (int i = 0; i < 4; i++) lk_bit(1'b0);
      lk_byte(8'h66);
      stb_high();
      @(negedge clk);
      check("midrst_tail_ram", disp_ram, '0);
      check("midrst_tail_frame_done", 128'(fd_count - fd_base), 128'd0);

      // Clean frame after reset uses auto-increment from address 1
      fd_base = fd_count;
      stb_low();
      lk_byte(8'hC1);
      lk_byte(8'h99);
      lk_byte(8'h98);
      stb_high();
      @(negedge clk);
      exp_ram = '0;
      exp_ram[15:8] = 8'h99;
      exp_ram[23:16] = 8'h98;
      check("postrst_ram", disp_ram, exp_ram);
      check("postrst_frame_done", 128'(fd_count - fd_base), 128'd1);

      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

endmodule
